// File: rtl/xor_stream_checksum.sv
// xor_stream_checksum: folds a LEN-word burst into a WIDTH-bit XOR checksum plus parity.
// Define XOR_ROTATE_EN to rotate the accumulator left by one before each fold (order-sensitive).
module xor_stream_checksum #(
    parameter int WIDTH = 16,
    parameter int MAX_LEN = 16,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LW-1:0]    len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [LW-1:0]    count
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t state, next;
    logic [WIDTH-1:0] acc, fold;
    logic [LW-1:0] rem, len_c;
    logic beat;
    assign in_ready  = state == ACCUM;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;
    always_comb begin
        beat  = in_valid && in_ready;
`ifdef XOR_ROTATE_EN
        fold  = ((acc << 1) | (acc >> (WIDTH - 1))) ^ in_data;
`else
        fold  = acc ^ in_data;
`endif
        len_c = (len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : len;
        next  = state == IDLE  ? (start ? (len == '0 ? DONE : ACCUM) : IDLE) :
                state == ACCUM ? ((beat && rem == LW'(1)) ? DONE : ACCUM) :
                                 (out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= next;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            rem    <= '0;
            count  <= '0;
            out    <= '0;
            parity <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                acc   <= '0;
                rem   <= len_c;
                count <= '0;
                if (len == '0) begin
                    out    <= '0;
                    parity <= 1'b0;
                end
            end
            if (beat) begin
                acc   <= fold;
                rem   <= rem - LW'(1);
                count <= count + LW'(1);
                if (rem == LW'(1)) begin
                    out    <= fold;
                    parity <= ^fold;
                end
            end
        end
    end
endmodule

// File: doc/xor_stream_checksum.md
Name: xor_stream_checksum

Overview:
- Parametrised, clocked successor to the 1-bit two-input XOR gate.
- Folds a burst of LEN words, each WIDTH bits wide, into one WIDTH-bit XOR checksum plus an overall parity bit.
- Uses valid/ready handshakes on both the input and the result sides.
- Sits between a word source (memory read port or bus) and a checker, as the team's first sequential XOR datapath block.

Parameters:
- WIDTH, 16: data and checksum width in bits; must be at least 1.
- MAX_LEN, 16: maximum burst length in words; the len port is $clog2(MAX_LEN+1) bits wide (LW).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin a burst; sampled only in IDLE.
- len  input  LW  number of words in the burst; sampled with start.
- in_valid  input  1  in_data is valid.
- in_data  input  WIDTH  word to fold.
- in_ready  output  1  block accepts a word this cycle.
- out  output  WIDTH  checksum, the XOR of all accepted words.
- parity  output  1  XOR-reduction of out.
- out_valid  output  1  out and parity are valid.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in ACCUM or DONE.
- count  output  LW  number of words accepted in the current burst.

Behaviour:
- Reset and clock:
  - One clock (clk); reset is synchronous and active-high.
  - Reset, whether at idle or mid-burst, forces state IDLE, acc=0, count=0, out=0, parity=0, out_valid=0, in_ready=0, busy=0.
  - A burst interrupted by reset is aborted; no result is produced.
- All outputs are registered or decoded from state; no combinational path from in_* to out_*.
- Handshakes: an input beat happens when in_valid&&in_ready; a result is consumed when out_valid&&out_ready. Stalls on either side are legal for any number of cycles.
- IDLE (in_ready=0, busy=0, out_valid=0):
  - start=1 and len>=1: acc<=0, rem<=min(len,MAX_LEN), count<=0, go to ACCUM.
  - start=1 and len=0: out<=0, parity<=0, go to DONE (empty checksum).
  - start=0: stay in IDLE.
- ACCUM (in_ready=1, busy=1):
  - On each beat: acc<=acc^in_data, rem<=rem-1, count<=count+1.
  - On the beat with rem==1: out<=acc^in_data, parity<=^(acc^in_data), go to DONE.
  - Latency: out_valid rises on the cycle after the final beat.
  - start is ignored in ACCUM.
- DONE (in_ready=0, busy=1, out_valid=1):
  - out, parity and count hold stable until out_ready=1, then go to IDLE.
  - start is ignored in DONE. Earliest restart is the cycle after the return to IDLE, so there is a 1-cycle gap between bursts.
- Width rules:
  - len > MAX_LEN is clamped to MAX_LEN.
  - count never exceeds MAX_LEN and does not wrap.
  - out holds its previous value in IDLE; it is not cleared until the next start.

Optional Feature:
- Macro: XOR_ROTATE_EN.
- Defined: each beat computes acc<={acc[WIDTH-2:0],acc[WIDTH-1]}^in_data (rotate left by 1, then XOR), making the checksum order-sensitive. For WIDTH=1 the rotate is identity.
- Undefined: plain XOR accumulation, which is order-insensitive.
- Handshake, latency and parity are identical in both builds.

Test Plan:
- WIDTH=1, LEN=2, four bursts {0,0},{0,1},{1,0},{1,1} -> out=0,1,1,0; parity equals out each time. This reproduces the 2-input XOR truth table.
- WIDTH=16, len=3, words 0x1234,0x00FF,0xF0F0 with in_valid deasserted for 2 cycles between words -> out=0xE23B, parity=1, count=3; out_valid rises 1 cycle after the third beat.
- Result back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and out is stable; start pulses are ignored; IDLE is entered the cycle after out_ready=1.
- len=0 -> DONE the next cycle with out=0x0000, parity=0, count=0. len=20 with MAX_LEN=16 -> exactly 16 beats accepted, then in_ready=0.
- Assert reset after 2 of 4 beats -> the next cycle shows IDLE, out_valid=0, count=0, busy=0. A following burst {0xAAAA} gives out=0xAAAA.
- XOR_ROTATE_EN, WIDTH=4, words {0x1,0x1} -> out=0x3. Without the macro -> out=0x0.
